axis_fifo: RTL and testbench

- Synchronous single-clock AXI-Stream FIFO: buffers words from an upstream AXI-Stream slave port (s_axis) and presents them in order on a downstream master port (m_axis).
- Exports empty, half and full status flags for flow monitoring.
- Sits between any AXI-Stream producer and consumer sharing one clock, absorbing backpressure up to DEPTH words.

---
 rtl/axis_if.sv | 12 +
 rtl/axis_fifo.sv | 73 +++++++
 tb/tb_axis_fifo.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_if.sv
// axis_if: AXI-Stream handshake/data bundle. The master drives tvalid/tdata and the slave
// drives tready.
interface axis_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_fifo.sv
// axis_fifo: single-clock AXI-Stream FIFO with first-word-fall-through output and status flags.
// Optional: define AXIS_FIFO_LEVEL_EN to add the fifo_level occupancy output.
module axis_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                   aclk,
    input  logic                   areset,
    axis_if.slave                  s_axis,
    axis_if.master                 m_axis,
    output logic                   fifo_empty,
    output logic                   fifo_half,
`ifdef AXIS_FIFO_LEVEL_EN
    output logic [$clog2(DEPTH):0] fifo_level,
`endif
    output logic                   fifo_full
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("axis_fifo: DEPTH must be a power of two and >= 4");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [AW:0]           occ;
    logic                  push, pop;

    // Flags derive only from the registered pointers; the MSB is the wrap bit.
    always_comb begin
        occ        = wr_ptr_q - rd_ptr_q;
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        // occ never exceeds DEPTH, so bit AW or AW-1 set means occ >= DEPTH/2.
        fifo_half  = occ[AW] | occ[AW-1];
    end

    always_comb begin
        s_axis.tready = !fifo_full;
        m_axis.tvalid = !fifo_empty;
        m_axis.tdata  = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_comb begin
        push     = s_axis.tvalid && !fifo_full;
        pop      = m_axis.tready && !fifo_empty;
        wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrOne : rd_ptr_q;
    end

`ifdef AXIS_FIFO_LEVEL_EN
    assign fifo_level = occ;
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately not reset; the output mux hides stale contents when empty.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= s_axis.tdata;
        end
    end
endmodule

// File: tb/tb_axis_fifo.sv
// tb_axis_fifo: directed and randomised self-checking bench for axis_fifo (DEPTH 16, 32-bit).
module tb_axis_fifo;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;

    logic aclk = 1'b0;
    logic areset;
    logic fifo_empty, fifo_half, fifo_full;
`ifdef AXIS_FIFO_LEVEL_EN
    logic [4:0] fifo_level;
`endif
    int checks   = 0;
    int failures = 0;

    axis_if #(.DATA_WIDTH(DW)) s_axis_if ();
    axis_if #(.DATA_WIDTH(DW)) m_axis_if ();

    axis_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .s_axis    (s_axis_if),
        .m_axis    (m_axis_if),
        .fifo_empty(fifo_empty),
        .fifo_half (fifo_half),
`ifdef AXIS_FIFO_LEVEL_EN
        .fifo_level(fifo_level),
`endif
        .fifo_full (fifo_full)
    );

    always #5 aclk = ~aclk;

    // {s.tready, m.tvalid, empty, half, full}
    logic [4:0] st;
    assign st = {s_axis_if.tready, m_axis_if.tvalid, fifo_empty, fifo_half, fifo_full};

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tdata  = '0;
        m_axis_if.tready = 1'b0;
        tick();
        tick();
        checks++;
        if (st !== 5'b10100) begin
            failures++;
            $display("FAIL reset_hold_status got=%b exp=10100", st);
        end
        areset = 1'b0;
        tick();
        checks++;
        if (st !== 5'b10100) begin
            failures++;
            $display("FAIL reset_status got=%b exp=10100", st);
        end
        checks++;
        if (m_axis_if.tdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_tdata got=%h exp=00000000", m_axis_if.tdata);
        end
    endtask

    task automatic test_single_word();
        s_axis_if.tvalid = 1'b1;
        s_axis_if.tdata  = 32'hDEADBEEF;
        m_axis_if.tready = 1'b0;
        tick();
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tdata  = 32'h12345678;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (st !== 5'b11000) begin
                failures++;
                $display("FAIL single_status cyc=%0d got=%b exp=11000", i, st);
            end
            checks++;
            if (m_axis_if.tdata !== 32'hDEADBEEF) begin
                failures++;
                $display("FAIL single_tdata cyc=%0d got=%h exp=deadbeef", i, m_axis_if.tdata);
            end
            tick();
        end
        m_axis_if.tready = 1'b1;
        tick();
        m_axis_if.tready = 1'b0;
        checks++;
        if (st !== 5'b10100) begin
            failures++;
            $display("FAIL single_pop_status got=%b exp=10100", st);
        end
    endtask

    task automatic test_fill();
        logic [4:0] exp;
        for (int i = 0; i < 16; i++) begin
            s_axis_if.tvalid = 1'b1;
            s_axis_if.tdata  = i;
            tick();
            exp = {(i + 1) != 16, 1'b1, 1'b0, (i + 1) >= 8, (i + 1) == 16};
            checks++;
            if (st !== exp) begin
                failures++;
                $display("FAIL fill_status n=%0d got=%b exp=%b", i + 1, st, exp);
            end
        end
        s_axis_if.tdata = 32'h99;
        tick();
        s_axis_if.tvalid = 1'b0;
        checks++;
        if (st !== 5'b01011 || m_axis_if.tdata !== 32'h0) begin
            failures++;
            $display("FAIL fill_overflow got=%b/%h exp=01011/00000000", st, m_axis_if.tdata);
        end
        m_axis_if.tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (m_axis_if.tdata !== i || !m_axis_if.tvalid) begin
                failures++;
                $display("FAIL drain_data i=%0d got=%h v=%b exp=%h", i, m_axis_if.tdata,
                         m_axis_if.tvalid, i);
            end
            tick();
        end
        m_axis_if.tready = 1'b0;
        checks++;
        if (st !== 5'b10100) begin
            failures++;
            $display("FAIL drain_empty got=%b exp=10100", st);
        end
    endtask

    task automatic test_full_simul();
        s_axis_if.tvalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_axis_if.tdata = 100 + i;
            tick();
        end
        s_axis_if.tdata = 32'h55;
        checks++;
        if (st !== 5'b01011) begin
            failures++;
            $display("FAIL simul_pre_full got=%b exp=01011", st);
        end
        m_axis_if.tready = 1'b1;
        tick();
        s_axis_if.tvalid = 1'b0;
        m_axis_if.tready = 1'b0;
        checks++;
        if (st !== 5'b11010) begin
            failures++;
            $display("FAIL simul_status got=%b exp=11010", st);
        end
        checks++;
        if (m_axis_if.tdata !== 32'd101) begin
            failures++;
            $display("FAIL simul_head got=%0d exp=101", m_axis_if.tdata);
        end
        m_axis_if.tready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            checks++;
            if (m_axis_if.tdata !== 100 + i) begin
                failures++;
                $display("FAIL simul_drain got=%0d exp=%0d", m_axis_if.tdata, 100 + i);
            end
            tick();
        end
        m_axis_if.tready = 1'b0;
        checks++;
        if (st !== 5'b10100) begin
            failures++;
            $display("FAIL simul_end got=%b exp=10100", st);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] data [100];
        for (int k = 0; k < 100; k++) data[k] = $urandom;
        s_axis_if.tvalid = 1'b1;
        s_axis_if.tdata  = data[0];
        m_axis_if.tready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (k < 99) s_axis_if.tdata = data[k + 1];
            else s_axis_if.tvalid = 1'b0;
            checks++;
            if (st !== 5'b11000 || m_axis_if.tdata !== data[k]) begin
                failures++;
                $display("FAIL stream k=%0d got=%b/%h exp=11000/%h", k, st, m_axis_if.tdata,
                         data[k]);
            end
        end
        tick();
        m_axis_if.tready = 1'b0;
        checks++;
        if (st !== 5'b10100) begin
            failures++;
            $display("FAIL stream_end got=%b exp=10100", st);
        end
    endtask

    task automatic test_soak();
        logic [31:0] q [$];
        logic [4:0]  exp;
        logic [31:0] exp_data;
        int          idle = 0;
        int          nfail = 0;
        int          pv, pr, sz;
        logic        push, pop;
        s_axis_if.tvalid = 1'b0;
        m_axis_if.tready = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            case ((cyc / 500) % 4)
                0: begin pv = 90;  pr = 20;  end
                1: begin pv = 20;  pr = 90;  end
                2: begin pv = 60;  pr = 60;  end
                default: begin pv = 100; pr = 100; end
            endcase
            // Producer holds a word until accepted; idle data is scrambled to show it is ignored.
            if (!s_axis_if.tvalid) begin
                s_axis_if.tvalid = ($urandom_range(99) < pv);
                s_axis_if.tdata  = $urandom;
            end
            m_axis_if.tready = ($urandom_range(99) < pr);
            sz = q.size();
            exp = {sz != 16, sz != 0, sz == 0, sz >= 8, sz == 16};
            exp_data = (sz != 0) ? q[0] : 32'h0;
            checks++;
            if (st !== exp || m_axis_if.tdata !== exp_data) begin
                failures++;
                nfail++;
                if (nfail <= 10)
                    $display("FAIL soak cyc=%0d got=%b/%h exp=%b/%h", cyc, st,
                             m_axis_if.tdata, exp, exp_data);
            end
`ifdef AXIS_FIFO_LEVEL_EN
            checks++;
            if (fifo_level !== 5'(sz)) begin
                failures++;
                $display("FAIL soak_level cyc=%0d got=%0d exp=%0d", cyc, fifo_level, sz);
            end
`endif
            push = s_axis_if.tvalid && (sz != 16);
            pop  = m_axis_if.tready && (sz != 0);
            tick();
            if (pop) begin
                void'(q.pop_front());
                idle = 0;
            end else if (sz != 0) begin
                idle++;
            end
            if (push) begin
                q.push_back(s_axis_if.tdata);
                s_axis_if.tvalid = 1'b0;
            end
            if (idle > 1000) begin
                checks++;
                failures++;
                $display("FAIL soak_hang cyc=%0d idle=%0d exp<=1000", cyc, idle);
                break;
            end
        end
        s_axis_if.tvalid = 1'b0;
        m_axis_if.tready = 1'b1;
        repeat (20) tick();
        m_axis_if.tready = 1'b0;
        checks++;
        if (st !== 5'b10100) begin
            failures++;
            $display("FAIL soak_drain got=%b exp=10100", st);
        end
    endtask

    task automatic test_reset_midop();
        for (int i = 0; i < 5; i++) begin
            s_axis_if.tvalid = 1'b1;
            s_axis_if.tdata  = 32'hA0 + i;
            tick();
        end
        s_axis_if.tvalid = 1'b0;
        checks++;
        if (st !== 5'b11000 || m_axis_if.tdata !== 32'hA0) begin
            failures++;
            $display("FAIL midop_pre got=%b/%h exp=11000/000000a0", st, m_axis_if.tdata);
        end
        areset = 1'b1;
        #1;
        checks++;
        if (st !== 5'b10100) begin
            failures++;
            $display("FAIL midop_async got=%b exp=10100", st);
        end
        tick();
        areset = 1'b0;
        tick();
        checks++;
        if (st !== 5'b10100 || m_axis_if.tdata !== 32'h0) begin
            failures++;
            $display("FAIL midop_release got=%b/%h exp=10100/00000000", st, m_axis_if.tdata);
        end
        m_axis_if.tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (m_axis_if.tvalid !== 1'b0) begin
                failures++;
                $display("FAIL midop_stale i=%0d got tvalid=%b data=%h exp tvalid=0", i,
                         m_axis_if.tvalid, m_axis_if.tdata);
            end
        end
        m_axis_if.tready = 1'b0;
        s_axis_if.tvalid = 1'b1;
        s_axis_if.tdata  = 32'hB0;
        tick();
        s_axis_if.tvalid = 1'b0;
        checks++;
        if (st !== 5'b11000 || m_axis_if.tdata !== 32'hB0) begin
            failures++;
            $display("FAIL midop_fresh got=%b/%h exp=11000/000000b0", st, m_axis_if.tdata);
        end
        m_axis_if.tready = 1'b1;
        tick();
        m_axis_if.tready = 1'b0;
        checks++;
        if (st !== 5'b10100) begin
            failures++;
            $display("FAIL midop_end got=%b exp=10100", st);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fill();
        test_full_simul();
        test_streaming();
        test_soak();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
